// File: rtl/attn_pkg.sv
// Shared types for the attention A*V path: precision codes, controller states,
// and the Q1.15 magnitude helper also used by the multiplier.
package attn_pkg;

  localparam int Q_W = 16;

  typedef enum logic [1:0] {
    PREC_INT4 = 2'b00,
    PREC_INT8 = 2'b01,
    PREC_FP16 = 2'b10
  } prec_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CLASSIFY,
    ST_START,
    ST_WAIT,
    ST_DONE
  } state_t;

  // Unsigned magnitude; 16'h8000 maps to 32768, which still fits in Q_W bits.
  function automatic logic [Q_W-1:0] abs_q15(input logic [Q_W-1:0] x);
    return x[Q_W-1] ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/attn_col_classifier.sv
// Threshold compare for one column's L1 sum into a precision code.
module attn_col_classifier
  import attn_pkg::*;
#(
  parameter int                SUM_W    = 19,
  parameter logic [SUM_W-1:0]  THR_LOW  = 19'h01000,
  parameter logic [SUM_W-1:0]  THR_HIGH = 19'h04000
) (
  input  logic [SUM_W-1:0] sum,
  output logic [1:0]       code
);

  always_comb begin
    code = PREC_INT4;
    if (sum >= THR_HIGH)     code = PREC_FP16;
    else if (sum >= THR_LOW) code = PREC_INT8;
  end

endmodule

// File: rtl/attn_precision_ctrl.sv
// Front end for the mixed-precision A*V multiplier: buffers the streamed matrix,
// classifies column precision, and runs the start/done handshake.
// Optional macro APC_TIMEOUT_EN adds a watchdog on the multiplier's done.
module attn_precision_ctrl
  import attn_pkg::*;
#(
  parameter int A_ROWS   = 8,
  parameter int NUM_COLS = 8,
  parameter int WIDTH    = 16,
  parameter logic [WIDTH+$clog2(A_ROWS)-1:0] THR_LOW  = 19'h01000,
  parameter logic [WIDTH+$clog2(A_ROWS)-1:0] THR_HIGH = 19'h04000,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               cmd_start,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic [WIDTH-1:0]                   s_data,
  input  logic                               s_last,
  output logic [A_ROWS*NUM_COLS*WIDTH-1:0]   a_mem_flat,
  output logic [2*NUM_COLS-1:0]              precision_sel_flat,
  output logic                               mul_start,
  input  logic                               mul_done,
  output logic                               busy,
  output logic                               done,
  output logic                               len_err,
  output logic                               timeout
);

  localparam int N     = A_ROWS * NUM_COLS;
  localparam int IW    = $clog2(N);
  localparam int CW    = $clog2(NUM_COLS);
  localparam int SUM_W = WIDTH + $clog2(A_ROWS);

  state_t state, nxt;

  logic [IW-1:0]                    idx;
  logic [CW-1:0]                    col;
  logic [NUM_COLS-1:0][SUM_W-1:0]   sums;
  logic [NUM_COLS-1:0][1:0]         codes;
  logic                             hs, last_beat, accept, expire;

  assign hs        = (state == ST_LOAD) && s_valid;
  assign last_beat = (idx == IW'(N-1));
  assign accept    = (state == ST_IDLE) && cmd_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt       = state;
    s_ready   = 1'b0;
    mul_start = 1'b0;
    done      = 1'b0;
    busy      = (state != ST_IDLE);
    case (state)
      ST_IDLE:     if (cmd_start) nxt = ST_LOAD;
      ST_LOAD: begin
        s_ready = 1'b1;
        if (s_valid && last_beat) nxt = ST_CLASSIFY;
      end
      ST_CLASSIFY: nxt = ST_START;
      ST_START: begin
        mul_start = 1'b1;
        nxt       = ST_WAIT;
      end
      ST_WAIT:     if (mul_done || expire) nxt = ST_DONE;
      ST_DONE: begin
        done = 1'b1;
        nxt  = ST_IDLE;
      end
      default:     nxt = ST_IDLE;
    endcase
  end

  // Buffer and codes are only written in LOAD/CLASSIFY, so they stay frozen
  // for the multiplier from START until the next accepted command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx                <= '0;
      col                <= '0;
      sums               <= '0;
      a_mem_flat         <= '0;
      precision_sel_flat <= '0;
      len_err            <= 1'b0;
    end else begin
      if (accept) begin
        idx     <= '0;
        col     <= '0;
        sums    <= '0;
        len_err <= 1'b0;
      end
      if (hs) begin
        a_mem_flat[idx*WIDTH +: WIDTH] <= s_data;
        sums[col] <= sums[col] + SUM_W'(abs_q15(s_data));
        idx       <= idx + 1'b1;
        col       <= (col == CW'(NUM_COLS-1)) ? '0 : col + 1'b1;
        if (s_last != last_beat) len_err <= 1'b1;
      end
      if (state == ST_CLASSIFY) precision_sel_flat <= codes;
    end
  end

  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    attn_col_classifier #(
      .SUM_W    (SUM_W),
      .THR_LOW  (THR_LOW),
      .THR_HIGH (THR_HIGH)
    ) u_cls (
      .sum  (sums[c]),
      .code (codes[c])
    );
  end

`ifdef APC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wcnt;

  // mul_done on the expiry cycle takes priority, so expiry requires it low.
  assign expire = (state == ST_WAIT) && !mul_done && (wcnt == TW'(TIMEOUT_CYCLES-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt    <= '0;
      timeout <= 1'b0;
    end else begin
      if (accept)                 timeout <= 1'b0;
      if (state == ST_START)      wcnt    <= '0;
      else if (state == ST_WAIT)  wcnt    <= wcnt + 1'b1;
      if (expire)                 timeout <= 1'b1;
    end
  end
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_attn_precision_ctrl.sv
// Scoreboard bench for attn_precision_ctrl: directed matrices, expected
// buffer/codes/flags queued at issue and checked on each done pulse.
module tb_attn_precision_ctrl;

  localparam int R = 8, C = 8, W = 16, N = R*C, MW = N*W;
  localparam int M_DONE = 0, M_RST = 1, M_TO = 2, M_EXP = 3;

  logic clk = 1'b0, rst_n = 1'b0, cmd_start = 1'b0, s_valid = 1'b0, s_last = 1'b0, mul_done = 1'b0;
  logic [W-1:0]   s_data = '0;
  logic           s_ready, mul_start, busy, done, len_err, timeout;
  logic [MW-1:0]  a_mem_flat;
  logic [2*C-1:0] precision_sel_flat;

  typedef struct {
    logic [MW-1:0]  mem;
    logic [2*C-1:0] prec;
    logic           len;
    logic           to;
  } exp_t;

  exp_t         sbq[$];
  int           total = 0, bad = 0, n_start = 0;
  logic [W-1:0] vec [N];

  attn_precision_ctrl #(.A_ROWS(R), .NUM_COLS(C), .WIDTH(W), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .a_mem_flat(a_mem_flat),
    .precision_sel_flat(precision_sel_flat), .mul_start(mul_start), .mul_done(mul_done),
    .busy(busy), .done(done), .len_err(len_err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_mem(input string nm, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      for (int k = 0; k < N; k++)
        if (act[k*W +: W] !== exp[k*W +: W]) begin
          $display("FAIL %s elem=%0d act=%h exp=%h", nm, k, act[k*W +: W], exp[k*W +: W]);
          break;
        end
    end
  endtask

  always @(negedge clk) if (rst_n && mul_start) n_start++;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (done) begin
      if (sbq.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_unexpected_done act=1 exp=0");
      end else begin
        e = sbq.pop_front();
        chk_mem("sb_mem", a_mem_flat, e.mem);
        chk("sb_prec", 64'(precision_sel_flat), 64'(e.prec));
        chk("sb_len_err", 64'(len_err), 64'(e.len));
        chk("sb_timeout", 64'(timeout), 64'(e.to));
      end
    end
  end

  // cols[c*W +: W] is the value placed in every row of column c.
  task automatic fill_cols(input logic [C*W-1:0] cols);
    for (int k = 0; k < N; k++) vec[k] = cols[(k % C)*W +: W];
  endtask

  task automatic run_xfer(input int last_pos, input bit gaps, input bit cmd_in_wait, input int mode,
                          input logic [2*C-1:0] exp_prec, input bit exp_len, input bit exp_to);
    exp_t e;
    int   starts0, i, cyc, n;
    bit   hs;
    starts0 = n_start;
    if (mode != M_RST) begin
      for (int k = 0; k < N; k++) e.mem[k*W +: W] = vec[k];
      e.prec = exp_prec; e.len = exp_len; e.to = exp_to;
      sbq.push_back(e);
    end
    @(posedge clk); #1 cmd_start = 1'b1;
    @(posedge clk); #1 cmd_start = 1'b0;
    chk("sticky_clr_len", 64'(len_err), 64'd0);
    chk("sticky_clr_to", 64'(timeout), 64'd0);
    i = 0; cyc = 0;
    while (i < N && cyc < 2000) begin
      s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data  = vec[i];
      s_last  = (i == last_pos);
      @(negedge clk); hs = s_valid && s_ready;
      @(posedge clk); #1;
      if (hs) i++;
      cyc++;
    end
    s_valid = 1'b0; s_last = 1'b0;
    chk("load_beats", 64'(i), 64'(N));
    n = 0;
    do begin @(negedge clk); n++; end while (!mul_start && n < 10);
    chk("mul_start_lat", 64'(n), 64'd2);
    if (cmd_in_wait) begin
      @(posedge clk); #1 cmd_start = 1'b1;
      @(posedge clk); #1 cmd_start = 1'b0;
      @(negedge clk);
      chk("wait_cmd_ignored_busy", 64'({busy, s_ready}), 64'b10);
    end
    case (mode)
      M_DONE: begin
        @(posedge clk); #1 mul_done = 1'b1;
        @(posedge clk); #1 mul_done = 1'b0;
        @(negedge clk); chk("done_lat", 64'(done), 64'd1);
      end
      M_RST: begin
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk("rst_ctl", 64'({busy, s_ready, mul_start, done, len_err, timeout}), 64'd0);
        chk("rst_prec", 64'(precision_sel_flat), 64'd0);
        chk_mem("rst_mem", a_mem_flat, '0);
        @(posedge clk); #1 rst_n = 1'b1;
      end
      M_TO: begin
        n = 0;
        do begin @(negedge clk); n++; end while (!done && n < 100);
        chk("timeout_lat", 64'(n), 64'd17);
      end
      default: begin
        repeat (16) @(posedge clk);
        #1 mul_done = 1'b1;
        @(posedge clk); #1 mul_done = 1'b0;
        @(negedge clk); chk("done_at_expiry", 64'(done), 64'd1);
      end
    endcase
    @(posedge clk); #1;
    chk("mul_start_cnt", 64'(n_start - starts0), 64'd1);
  endtask

  initial begin
    #1;
    chk("reset_ctl", 64'({busy, s_ready, mul_start, done, len_err, timeout}), 64'd0);
    chk("reset_prec", 64'(precision_sel_flat), 64'd0);
    chk_mem("reset_mem", a_mem_flat, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    s_valid = 1'b1;
    @(negedge clk);
    chk("idle_not_ready", 64'({busy, s_ready}), 64'd0);
    s_valid = 1'b0;

    fill_cols({C{16'h0100}});
    run_xfer(N-1, 1'b0, 1'b0, M_DONE, 16'h0000, 1'b0, 1'b0);

    fill_cols({96'h0, 16'h0400, 16'h8000});
    run_xfer(N-1, 1'b0, 1'b0, M_DONE, 16'h0006, 1'b0, 1'b0);

    run_xfer(N-1, 1'b1, 1'b1, M_DONE, 16'h0006, 1'b0, 1'b0);

    fill_cols({C{16'h0100}});
    run_xfer(10, 1'b0, 1'b0, M_DONE, 16'h0000, 1'b1, 1'b0);

    fill_cols({96'h0, 16'h0400, 16'h8000});
    run_xfer(N-1, 1'b0, 1'b0, M_RST, 16'h0000, 1'b0, 1'b0);

    // Exact-threshold columns: 0x4000 -> FP16, 0x1000 -> INT8, 0xFF8 -> INT4.
    fill_cols({16'hFC00, 16'h0800, 16'h0200, 16'h01FF, 64'h0});
    run_xfer(N-1, 1'b0, 1'b0, M_DONE, 16'h6400, 1'b0, 1'b0);

`ifdef APC_TIMEOUT_EN
    fill_cols({C{16'h0100}});
    run_xfer(N-1, 1'b0, 1'b0, M_TO, 16'h0000, 1'b0, 1'b1);
    run_xfer(N-1, 1'b0, 1'b0, M_EXP, 16'h0000, 1'b0, 1'b0);
`endif

    repeat (3) @(posedge clk);
    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
